fpu_addsub_seq: RTL and testbench

FPU_ADDSUB_SEQ -- requirements
Module: fpu_addsub_seq

---
 rtl/fpu_addsub_seq.sv | 105 ++++++++++
 tb/tb_fpu_addsub_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: arbitrates two requesters onto one shared FP add/sub unit and returns a response.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b (N=0,1)  request channels; op 3 = add, 10 = sub
//   unit_start/a/b/addbar_sub        command to the shared unit
//   unit_done/result                 completion pulse and result from the unit
//   rsp_valid/ready/id/result/err    response channel
module fpu_addsub_seq #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        unit_start,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        unit_addbar_sub,
   input  logic        unit_done,
   input  logic [31:0] unit_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_err
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_nx;
   logic fav, gnt, acc, legal, busy, expired;
   logic cur_id, cur_add, err;
   logic [3:0] sel_op;
   logic [31:0] cur_a, cur_b, res;
   logic [7:0] cnt;
   // fav names the requester that wins when both are valid
   always_comb begin
      gnt = (req0_valid && req1_valid) ? fav : req1_valid;
      acc = state == IDLE && !rst && (req0_valid || req1_valid);
      req0_ready = acc && !gnt;
      req1_ready = acc && gnt;
      sel_op = gnt ? req1_op : req0_op;
      legal = sel_op == 4'd3 || sel_op == 4'd10;
      expired = cnt == 8'(TIMEOUT - 1);
      busy = state == ISSUE || state == WAIT;
      unit_start = state == ISSUE;
      unit_a = busy ? cur_a : 32'd0;
      unit_b = busy ? cur_b : 32'd0;
      unit_addbar_sub = busy && cur_add;
      rsp_valid = state == RESP;
      rsp_id = rsp_valid && cur_id;
      rsp_err = rsp_valid && err;
      rsp_result = rsp_valid ? res : 32'd0;
      state_nx = state;
      case (state)
         IDLE:  state_nx = acc ? (legal ? ISSUE : RESP) : IDLE;
         ISSUE: state_nx = WAIT;
         WAIT:  state_nx = (unit_done || expired) ? RESP : WAIT;
         RESP:  state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         fav <= 1'b0;
         cur_id <= 1'b0;
         cur_add <= 1'b0;
         cur_a <= 32'd0;
         cur_b <= 32'd0;
         res <= 32'd0;
         err <= 1'b0;
         cnt <= 8'd0;
      end else begin
         state <= state_nx;
         if (acc) begin
            fav <= ~gnt;
            cur_id <= gnt;
            cur_add <= sel_op == 4'd3;
            cur_a <= gnt ? req1_a : req0_a;
            cur_b <= gnt ? req1_b : req0_b;
            err <= ~legal;
            res <= 32'd0;
         end
         if (state == ISSUE) cnt <= 8'd0;
         if (state == WAIT) begin
            cnt <= cnt + 8'd1;
            // a completion on the final cycle still wins over the timeout
            if (unit_done) begin
               res <= unit_result;
               err <= 1'b0;
            end else if (expired) begin
               res <= 32'd0;
               err <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb_fpu_addsub_seq: directed and randomized checks of fpu_addsub_seq against a transaction-level model.
module tb_fpu_addsub_seq;
   localparam int TO = 16;
   logic clk = 0, rst = 1;
   logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
   logic [3:0] req0_op = 0, req1_op = 0;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic unit_start, unit_addbar_sub, unit_done = 0, rsp_valid, rsp_ready = 0, rsp_id, rsp_err;
   logic [31:0] unit_a, unit_b, unit_result = 0, rsp_result;
   int total = 0, passed = 0;
   // model: phase 0 idle, 1 issuing, 2 waiting on unit, 3 holding response
   int m_phase = 0, m_waited = 0;
   logic m_fav = 0, m_id = 0, m_add = 0, m_err = 0;
   logic [31:0] m_a = 0, m_b = 0, m_res = 0;
   fpu_addsub_seq #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b), .unit_addbar_sub(unit_addbar_sub),
      .unit_done(unit_done), .unit_result(unit_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s got %h want %h", nm, act, exp);
   endtask
   function automatic logic grant_of();
      return (req0_valid && req1_valid) ? m_fav : req1_valid;
   endfunction
   task automatic compare();
      logic acc, g, busy, rv;
      acc = m_phase == 0 && !rst && (req0_valid || req1_valid);
      g = grant_of();
      busy = m_phase == 1 || m_phase == 2;
      rv = m_phase == 3;
      chk("ctl", {25'd0, req0_ready, req1_ready, unit_start, unit_addbar_sub, rsp_valid, rsp_id, rsp_err},
          {25'd0, acc && !g, acc && g, m_phase == 1, busy && m_add, rv, rv && m_id, rv && m_err});
      chk("unit_a", unit_a, busy ? m_a : 32'd0);
      chk("unit_b", unit_b, busy ? m_b : 32'd0);
      chk("rsp_result", rsp_result, rv ? m_res : 32'd0);
   endtask
   task automatic model_update();
      logic g;
      logic [3:0] op;
      if (rst) begin
         m_phase = 0; m_fav = 0; m_waited = 0; m_id = 0; m_add = 0; m_err = 0; m_a = 0; m_b = 0; m_res = 0;
         return;
      end
      case (m_phase)
         0: if (req0_valid || req1_valid) begin
            g = grant_of();
            op = g ? req1_op : req0_op;
            m_fav = !g; m_id = g; m_add = op == 4'd3;
            m_a = g ? req1_a : req0_a;
            m_b = g ? req1_b : req0_b;
            m_res = 0;
            m_err = !(op == 4'd3 || op == 4'd10);
            m_phase = m_err ? 3 : 1;
         end
         1: begin m_phase = 2; m_waited = 0; end
         2: begin
            m_waited++;
            if (unit_done) begin m_res = unit_result; m_err = 0; m_phase = 3; end
            else if (m_waited == TO) begin m_res = 0; m_err = 1; m_phase = 3; end
         end
         default: if (rsp_ready) m_phase = 0;
      endcase
   endtask
   task automatic step();
      #1 compare();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask
   initial begin
      int n, adds;
      logic [7:0] grants;
      @(negedge clk);
      step(); step();
      chk("reset rsp_valid", {31'd0, rsp_valid}, 0);
      chk("reset unit_start", {31'd0, unit_start}, 0);
      // single add, unit answers on the first wait cycle
      rst = 0;
      req0_valid = 1; req0_op = 3; req0_a = 32'h3F800000; req0_b = 32'h40000000;
      step();
      req0_valid = 0; req0_a = 32'hDEADBEEF;
      chk("add start", {31'd0, unit_start}, 1);
      chk("add addbar", {31'd0, unit_addbar_sub}, 1);
      chk("add unit_a", unit_a, 32'h3F800000);
      step();
      unit_done = 1; unit_result = 32'h40400000;
      chk("add no restart", {31'd0, unit_start}, 0);
      step();
      unit_done = 0;
      chk("add rsp_valid", {31'd0, rsp_valid}, 1);
      chk("add rsp_id", {31'd0, rsp_id}, 0);
      chk("add rsp_result", rsp_result, 32'h40400000);
      chk("add rsp_err", {31'd0, rsp_err}, 0);
      rsp_ready = 1;
      step();
      // round robin after reset with both requesters always valid
      rst = 1; step(); rst = 0;
      req0_valid = 1; req1_valid = 1; req0_op = 10; req1_op = 10;
      req0_a = 32'h11111111; req1_a = 32'h22222222; unit_done = 1;
      n = 0; adds = 0; grants = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((req0_ready || req1_ready) && n < 8) begin grants[n] = req1_ready; n++; end
         if (unit_start && unit_addbar_sub) adds++;
         step();
      end
      chk("rr grants", {28'd0, grants[3:0]}, 32'b1010);
      chk("rr sub only", adds, 0);
      req0_valid = 0; req1_valid = 0; unit_done = 0;
      step(); step(); step();
      // illegal opcode from requester 1
      req1_valid = 1; req1_op = 5; rsp_ready = 0;
      step();
      req1_valid = 0;
      chk("ill rsp_valid", {31'd0, rsp_valid}, 1);
      chk("ill rsp_id", {31'd0, rsp_id}, 1);
      chk("ill rsp_err", {31'd0, rsp_err}, 1);
      chk("ill rsp_result", rsp_result, 0);
      chk("ill no start", {31'd0, unit_start}, 0);
      rsp_ready = 1; step(); rsp_ready = 0;
      // timeout, then a stalled response with late completions
      req0_valid = 1; req0_op = 3;
      step();
      req0_valid = 0;
      step();
      n = 0;
      while (!rsp_valid && n < 40) begin step(); n++; end
      chk("timeout cycles", n, TO);
      chk("timeout err", {31'd0, rsp_err}, 1);
      req0_valid = 1; req1_valid = 1; unit_done = 1; unit_result = 32'h12345678;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall readies", {30'd0, req0_ready, req1_ready}, 0);
         chk("stall result", rsp_result, 0);
         step();
      end
      req0_valid = 0; req1_valid = 0; unit_done = 0; rsp_ready = 1;
      step();
      // reset while waiting aborts the operation
      rsp_ready = 0; req1_valid = 1; req1_op = 10; req1_b = 32'h55AA55AA;
      step();
      req1_valid = 0;
      step();
      rst = 1; step(); rst = 0;
      chk("abort unit_b", unit_b, 0);
      chk("abort rsp_valid", {31'd0, rsp_valid}, 0);
      unit_done = 1; step(); unit_done = 0; step();
      chk("abort no rsp", {31'd0, rsp_valid}, 0);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom % 300) == 0;
         req0_valid = $urandom % 2; req1_valid = $urandom % 2;
         req0_op = ($urandom % 6 == 0) ? 4'($urandom) : (($urandom % 2) ? 4'd3 : 4'd10);
         req1_op = ($urandom % 6 == 0) ? 4'($urandom) : (($urandom % 2) ? 4'd3 : 4'd10);
         req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
         unit_done = ($urandom % 8) == 0; unit_result = $urandom;
         rsp_ready = $urandom % 2;
         step();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
